// File: rtl/rd_hazard_tracker.sv
// rd_hazard_tracker: follows destination registers issued from decode through
// EX, MEM and WB. It stalls decode on load-use hazards, produces registered
// forwarding selects aligned to the EX stage, publishes a busy mask of
// in-flight writes, and keeps a saturating count of stall cycles.
module rd_hazard_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [REG_ADDR_W-1:0]       id_rd,
  input  logic                        id_reg_write,
  input  logic                        id_mem_read,
  input  logic [REG_ADDR_W-1:0]       id_rs1,
  input  logic [REG_ADDR_W-1:0]       id_rs2,
  input  logic                        flush,
  output logic                        stall_out,
  output logic [1:0]                  fwd_rs1_sel,
  output logic [1:0]                  fwd_rs2_sel,
  output logic [(2**REG_ADDR_W)-1:0]  busy_mask,
  output logic [CNT_W-1:0]            stall_count
);

  // Forwarding select encoding for the EX-stage operand muxes.
  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A tracked write: valid only for reg_write with rd != x0. The load flag
  // matters only while the producer sits in EX, so it is kept for EX alone.
  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  entry_t           ex_q, ex_d;
  entry_t           mem_q;
  entry_t           wb_q;
  logic             ex_ld_q, ex_ld_d;
  logic [1:0]       fwd1_q, fwd1_d;
  logic [1:0]       fwd2_q, fwd2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             live_id;
  logic             accept;

  // Select for one source operand of the instruction about to enter EX.
  // The producer now in EX will be in EX/MEM next cycle; the one in MEM will
  // be in MEM/WB. The youngest producer wins. A WB match reads through the
  // register file, so it needs no forwarding.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input entry_t                ex,
    input entry_t                mem
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (rs != '0) begin
      if (ex.vld && (ex.rd == rs)) begin
        sel = SEL_EXMEM;
      end else if (mem.vld && (mem.rd == rs)) begin
        sel = SEL_MEMWB;
      end
    end
    return sel;
  endfunction

  // Load-use detection and the accept decision for the ID instruction.
  // A flush squashes the ID instruction, so it overrides any hazard.
  always_comb begin
    live_id   = id_valid && !flush;
    stall_out = live_id && ex_q.vld && ex_ld_q &&
                ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    accept    = live_id && !stall_out;
  end

  // Next EX entry and next forwarding selects; a non-accepted slot is a bubble.
  always_comb begin
    ex_d.vld = accept && id_reg_write && (id_rd != '0);
    ex_d.rd  = id_rd;
    ex_ld_d  = id_mem_read;
    fwd1_d   = SEL_RF;
    fwd2_d   = SEL_RF;
    if (accept) begin
      fwd1_d = fwd_sel(id_rs1, ex_q, mem_q);
      fwd2_d = fwd_sel(id_rs2, ex_q, mem_q);
    end
  end

  // Stall counter saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_out && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pipeline tracking registers advance every cycle; reset empties them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      ex_ld_q <= 1'b0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd1_q  <= SEL_RF;
      fwd2_q  <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      ex_ld_q <= ex_ld_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd1_q  <= fwd1_d;
      fwd2_q  <= fwd2_d;
      cnt_q   <= cnt_d;
    end
  end

  // Busy mask: one bit per register with a write still in flight.
  always_comb begin
    busy_mask = '0;
    if (ex_q.vld)  busy_mask[ex_q.rd]  = 1'b1;
    if (mem_q.vld) busy_mask[mem_q.rd] = 1'b1;
    if (wb_q.vld)  busy_mask[wb_q.rd]  = 1'b1;
    busy_mask[0] = 1'b0;
  end

  assign fwd_rs1_sel = fwd1_q;
  assign fwd_rs2_sel = fwd2_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_rd_hazard_tracker.sv
// Testbench for rd_hazard_tracker: directed per-cycle vectors push expected
// outputs into a queue; a negedge monitor pops and compares them.
module tb_rd_hazard_tracker;

  localparam int AW = 5;
  localparam int CW = 2;

  localparam int M_ST  = 1;
  localparam int M_F1  = 2;
  localparam int M_F2  = 4;
  localparam int M_B   = 8;
  localparam int M_C   = 16;
  localparam int M_ALL = 31;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          flush;
  logic          stall_out;
  logic [1:0]    fwd_rs1_sel;
  logic [1:0]    fwd_rs2_sel;
  logic [31:0]   busy_mask;
  logic [CW-1:0] stall_count;

  rd_hazard_tracker #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .flush        (flush),
    .stall_out    (stall_out),
    .fwd_rs1_sel  (fwd_rs1_sel),
    .fwd_rs2_sel  (fwd_rs2_sel),
    .busy_mask    (busy_mask),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [4:0]  m;
    logic        st;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] b;
    logic [1:0]  c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
  endtask

  // Monitor: outputs are sampled mid-cycle, after the inputs have settled.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.m[0]) chk({e.nm, ".stall"}, {31'd0, stall_out}, {31'd0, e.st});
      if (e.m[1]) chk({e.nm, ".fwd1"}, {30'd0, fwd_rs1_sel}, {30'd0, e.f1});
      if (e.m[2]) chk({e.nm, ".fwd2"}, {30'd0, fwd_rs2_sel}, {30'd0, e.f2});
      if (e.m[3]) chk({e.nm, ".busy"}, busy_mask, e.b);
      if (e.m[4]) chk({e.nm, ".cnt"}, {30'd0, stall_count}, {30'd0, e.c});
    end
  end

  // One cycle: drive inputs just after the edge and queue the outputs
  // expected for this cycle.
  task automatic step(input string nm, input int r, input int v, input int rd,
                      input int rw, input int ml, input int s1, input int s2,
                      input int fl, input int m, input int st, input int f1,
                      input int f2, input int b, input int c);
    exp_t t;
    @(posedge clk);
    #1;
    rst_n        = (r == 0);
    id_valid     = (v != 0);
    id_rd        = AW'(rd);
    id_reg_write = (rw != 0);
    id_mem_read  = (ml != 0);
    id_rs1       = AW'(s1);
    id_rs2       = AW'(s2);
    flush        = (fl != 0);
    t.nm = nm;
    t.m  = 5'(m);
    t.st = (st != 0);
    t.f1 = 2'(f1);
    t.f2 = 2'(f2);
    t.b  = 32'(b);
    t.c  = 2'(c);
    q.push_back(t);
  endtask

  task automatic idle(input string nm, input int f1, input int f2, input int b, input int c);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, M_ALL, 0, f1, f2, b, c);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned rv;
    int waited;
    rst_n = 1'b0; id_valid = 1'b0; id_rd = '0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; id_rs1 = '0; id_rs2 = '0; flush = 1'b0;

    // Reset held with random inputs: everything reads zero.
    for (int i = 0; i < 4; i++) begin
      rv = $urandom;
      step("rst_rand", 1, int'(rv & 1), int'((rv >> 1) & 31), int'((rv >> 6) & 1),
           int'((rv >> 7) & 1), int'((rv >> 8) & 31), int'((rv >> 13) & 31),
           int'((rv >> 18) & 1), M_ALL, 0, 0, 0, 0, 0);
    end
    idle("rst_rel0", 0, 0, 0, 0);
    idle("rst_rel1", 0, 0, 0, 0);

    // ALU back-to-back: EX/MEM forward, busy for three cycles.
    step("t2_add5", 0, 1, 5, 1, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    step("t2_use5", 0, 1, 8, 0, 0, 5, 6, 0, M_ALL, 0, 0, 0, 1 << 5, 0);
    idle("t2_fwd", 1, 0, 1 << 5, 0);
    idle("t2_busy3", 0, 0, 1 << 5, 0);
    idle("t2_busy0", 0, 0, 0, 0);

    // Distance 2 -> MEM/WB forward; distance 3 (WB) -> register file.
    step("t3_add7", 0, 1, 7, 1, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    step("t3_unrel", 0, 1, 0, 0, 0, 2, 3, 0, M_ALL, 0, 0, 0, 1 << 7, 0);
    step("t3_use7", 0, 1, 0, 0, 0, 0, 7, 0, M_ALL, 0, 0, 0, 1 << 7, 0);
    idle("t3_d2", 0, 2, 1 << 7, 0);
    step("t3_add9", 0, 1, 9, 1, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    step("t3_u1", 0, 1, 0, 0, 0, 0, 0, 0, M_ALL, 0, 0, 0, 1 << 9, 0);
    step("t3_u2", 0, 1, 0, 0, 0, 0, 0, 0, M_ALL, 0, 0, 0, 1 << 9, 0);
    step("t3_use9", 0, 1, 0, 0, 0, 0, 9, 0, M_ALL, 0, 0, 0, 1 << 9, 0);
    idle("t3_d3", 0, 0, 0, 0);
    // rs1 == rs2, both matching the EX producer.
    step("t3_add20", 0, 1, 20, 1, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    step("t3_dup", 0, 1, 0, 0, 0, 20, 20, 0, M_ALL, 0, 0, 0, 1 << 20, 0);
    idle("t3_dupfwd", 1, 1, 1 << 20, 0);

    // Load-use: one stall cycle, then MEM/WB forward; x0 load never stalls.
    step("t4_lw10", 0, 1, 10, 1, 1, 0, 0, 0, M_ALL, 0, 0, 0, 1 << 20, 0);
    step("t4_stall", 0, 1, 0, 0, 0, 10, 0, 0, M_ALL, 1, 0, 0, 1 << 10, 0);
    step("t4_held", 0, 1, 0, 0, 0, 10, 0, 0, M_ALL, 0, 0, 0, 1 << 10, 1);
    idle("t4_fwd", 2, 0, 1 << 10, 1);
    step("t4_lwx0", 0, 1, 0, 1, 1, 0, 0, 0, M_ALL, 0, 0, 0, 0, 1);
    step("t4_usex0", 0, 1, 0, 0, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 1);
    idle("t4_x0fwd", 0, 0, 0, 1);

    // Flush during load-use: no stall, bubble, count unchanged.
    step("t5_lw3", 0, 1, 3, 1, 1, 0, 0, 0, M_ALL, 0, 0, 0, 0, 1);
    step("t5_flush", 0, 1, 4, 1, 0, 0, 3, 1, M_ALL, 0, 0, 0, 1 << 3, 1);
    idle("t5_after", 0, 0, 1 << 3, 1);

    // Counter saturation (CW=2) and asynchronous reset mid-sequence.
    step("t6_rst", 1, 0, 0, 0, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    idle("t6_rel", 0, 0, 0, 0);
    step("t6_lw10", 0, 1, 10, 1, 1, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    step("t6_s1", 0, 1, 11, 1, 1, 10, 0, 0, M_ST | M_C, 1, 0, 0, 0, 0);
    step("t6_a1", 0, 1, 11, 1, 1, 10, 0, 0, M_ST | M_C, 0, 0, 0, 0, 1);
    step("t6_s2", 0, 1, 12, 1, 1, 11, 0, 0, M_ST | M_F1 | M_C, 1, 2, 0, 0, 1);
    step("t6_a2", 0, 1, 12, 1, 1, 11, 0, 0, M_ST | M_C, 0, 0, 0, 0, 2);
    step("t6_s3", 0, 1, 13, 1, 1, 12, 0, 0, M_ST | M_C, 1, 0, 0, 0, 2);
    step("t6_a3", 0, 1, 13, 1, 1, 12, 0, 0, M_ST | M_C, 0, 0, 0, 0, 3);
    step("t6_s4", 0, 1, 14, 1, 1, 13, 0, 0, M_ST | M_C, 1, 0, 0, 0, 3);
    step("t6_a4", 0, 1, 14, 1, 1, 13, 0, 0, M_ST | M_C, 0, 0, 0, 0, 3);
    step("t6_s5", 0, 1, 15, 1, 1, 14, 0, 0, M_ST | M_C, 1, 0, 0, 0, 3);
    step("t6_a5", 0, 1, 15, 1, 1, 14, 0, 0, M_ST | M_C, 0, 0, 0, 0, 3);
    step("t6_rstmid", 1, 1, 1, 1, 1, 15, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    step("t6_first", 0, 1, 2, 1, 1, 15, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    idle("t6_empty", 0, 0, 1 << 2, 0);

    // Let the monitor drain the queue, bounded.
    waited = 0;
    while (q.size() != 0 && waited < 5) begin
      @(negedge clk);
      #1;
      waited++;
    end
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rd_hazard_tracker.md
Name: rd_hazard_tracker

Overview:
- Consumer end of the rd_out destination-register stream from the decode stage of the RISC-V core.
- Tracks in-flight destination registers through EX, MEM and WB.
- Detects load-use hazards and stalls decode.
- Produces registered forwarding selects, aligned to the EX stage, for the EX-stage operand muxes.

Parameters:
REG_ADDR_W, 5, register address width (32 architectural registers)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  valid instruction present in ID
id_rd  input  REG_ADDR_W  destination register of ID instruction (rd_out)
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
id_rs1  input  REG_ADDR_W  source register 1 of ID instruction
id_rs2  input  REG_ADDR_W  source register 2 of ID instruction
flush  input  1  squash ID instruction (branch taken in EX)
stall_out  output  1  hold PC and IF/ID; insert bubble into EX
fwd_rs1_sel  output  2  EX-stage rs1 source: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_rs2_sel  output  2  EX-stage rs2 source, same encoding
busy_mask  output  32  bit i = register i has an in-flight write
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset is asynchronous and active-low on rst_n; one clock, clk.

Tracking entries
- Three entries: EX, MEM, WB. Each holds {valid, rd, is_load}.
- An entry is valid only if reg_write=1 and rd!=0. Writes to x0 are never tracked, forwarded or stalled.

Reset (rst_n=0, asynchronous)
- All entries invalid.
- fwd_rs1_sel=fwd_rs2_sel=00.
- stall_count=0.
- stall_out=0 and busy_mask=0, because both are derived from the entries.

Accept condition
- accept = id_valid & !flush & !stall_out.

stall_out (combinational)
- Asserted when id_valid & !flush & EX.valid & EX.is_load, and EX.rd==id_rs1 or EX.rd==id_rs2.
- Load-use only. No other hazard stalls.

Per rising edge, entries advance unconditionally
- WB <= MEM.
- MEM <= EX.
- EX <= {accept & id_reg_write & id_rd!=0, id_rd, id_mem_read}.
- A stall or flush puts a bubble (invalid entry) into EX.

Forwarding selects (registered; one-cycle latency; valid while the accepted instruction sits in EX)
- When accept, for each rsN:
  - rsN!=0 and EX.valid and EX.rd==rsN -> 01 (producer will be in EX/MEM).
  - else rsN!=0 and MEM.valid and MEM.rd==rsN -> 10 (producer will be in MEM/WB).
  - else -> 00.
- When not accept -> 00 (bubble).
- Priority: youngest producer wins (EX over MEM).
- A match on WB gives 00. The register file writes through in the same cycle.

busy_mask (combinational)
- OR of one-hot(rd) over the valid entries.
- Bit 0 is always 0.

stall_count
- Increments on each edge where stall_out=1.
- Saturates at 2^CNT_W-1. No wrap.

Simultaneous events
- flush and a would-be hazard in the same cycle: flush wins. stall_out=0, bubble inserted, no count.
- rs1==rs2, both matching: both selects are set identically.
- Load in EX with rd=0: no stall.

Reset mid-operation
- All state clears immediately.
- The first edge after deassertion behaves as an empty pipeline.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> stall_out=0, fwd selects 00, busy_mask=0, stall_count=0; deassert with id_valid=0 -> all remain 0.
2. ALU back-to-back: accept add x5 (reg_write=1), next cycle ID rs1=x5, rs2=x6 -> after edge fwd_rs1_sel=01, fwd_rs2_sel=00; busy_mask bit5=1 for 3 cycles after the first edge, then 0.
3. Distance-2: add x7, then an unrelated instr, then rs2=x7 -> fwd_rs2_sel=10; distance-3 -> 00.
4. Load-use: lw x10, then ID rs1=x10 -> stall_out=1 for exactly one cycle; stall_count=1; on the next accept fwd_rs1_sel=10; lw x0 followed by rs1=x0 -> no stall, select 00.
5. Flush during a load-use condition: lw x3, then ID rs2=x3 with flush=1 -> stall_out=0, EX bubble, fwd 00, stall_count unchanged.
6. Counter saturation with CNT_W=2: force 5 consecutive load-use stalls -> stall_count sequence 1,2,3,3,3; an async reset mid-sequence -> immediately 0.
